// File: rtl/axicb_mst_switch_rd_pkg.sv
// Shared types and width helpers for the slave-side read switch.
package axicb_mst_switch_rd_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axicb_mst_switch_rd_round_robin.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last winner.
module axicb_round_robin
  import axicb_mst_switch_rd_pkg::*;
#(
  parameter int unsigned REQ_NB = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              en,
  input  logic [REQ_NB-1:0] req,
  output logic [REQ_NB-1:0] grant
);

  localparam int unsigned IdxW = idx_width(REQ_NB);

  logic [IdxW-1:0] last_q;
  logic [IdxW-1:0] win;
  logic            found;

  always_comb begin : p_pick
    int unsigned j;
    j     = 0;
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= REQ_NB; off++) begin
      j = (32'(last_q) + off) % REQ_NB;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win      = IdxW'(j);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_q <= IdxW'(REQ_NB - 1);
    end else if (srst) begin
      last_q <= IdxW'(REQ_NB - 1);
    end else if (en && found) begin
      last_q <= win;
    end
  end

endmodule

// File: rtl/axicb_mst_switch_rd.sv
// Slave-side read switch: arbitrates master ARs onto one slave and routes R beats back in order.
module axicb_mst_switch_rd
  import axicb_mst_switch_rd_pkg::*;
#(
  parameter int unsigned MST_NB     = 4,
  parameter int unsigned ARCH_W     = 8,
  parameter int unsigned RCH_W      = 8,
  parameter int unsigned OSTDREQ_NB = 4
) (
  input  logic                     aclk,
  input  logic                     srst,
  input  logic [MST_NB-1:0]        i_arvalid,
  output logic [MST_NB-1:0]        i_arready,
  input  logic [MST_NB*ARCH_W-1:0] i_arch,
  output logic [MST_NB-1:0]        i_rvalid,
  input  logic [MST_NB-1:0]        i_rready,
  output logic [MST_NB-1:0]        i_rlast,
  output logic [RCH_W-1:0]         i_rch,
  output logic                     o_arvalid,
  input  logic                     o_arready,
  output logic [ARCH_W-1:0]        o_arch,
  input  logic                     o_rvalid,
  output logic                     o_rready,
  input  logic                     o_rlast,
  input  logic [RCH_W-1:0]         o_rch
);

  localparam int unsigned IdxW = idx_width(MST_NB);
  localparam int unsigned PtrW = $clog2(OSTDREQ_NB);
  localparam int unsigned CntW = PtrW + 1;

  arb_state_e        state_q;
  logic [IdxW-1:0]   lock_idx_q;
  logic [IdxW-1:0]   rr_idx;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW-1:0]   head_idx;
  logic [MST_NB-1:0] rr_req;
  logic [MST_NB-1:0] rr_grant;
  logic [IdxW-1:0]   fifo_q [OSTDREQ_NB];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              full;
  logic              empty;
  logic              ar_hs;
  logic              r_pop;

  assign full  = (cnt_q == CntW'(OSTDREQ_NB));
  assign empty = (cnt_q == '0);

  // While locked only the held master may win, so the pointer lands on it at handshake.
  always_comb begin
    rr_req = i_arvalid;
    if (state_q == StLocked) begin
      rr_req             = '0;
      rr_req[lock_idx_q] = i_arvalid[lock_idx_q];
    end
    rr_idx = '0;
    for (int unsigned k = 0; k < MST_NB; k++) begin
      if (rr_grant[k]) rr_idx = IdxW'(k);
    end
  end

  axicb_round_robin #(
    .REQ_NB (MST_NB)
  ) u_rr (
    .aclk    (aclk),
    .aresetn (1'b1),
    .srst    (srst),
    .en      (ar_hs),
    .req     (rr_req),
    .grant   (rr_grant)
  );

  assign grant_idx = (state_q == StLocked) ? lock_idx_q : rr_idx;

  always_comb begin
    o_arvalid = 1'b0;
    i_arready = '0;
    o_arch    = i_arch[0 +: ARCH_W];
    for (int unsigned k = 0; k < MST_NB; k++) begin
      if (grant_idx == IdxW'(k)) begin
        o_arvalid    = i_arvalid[k] & ~full & ~srst;
        i_arready[k] = o_arready & ~full & ~srst;
        o_arch       = i_arch[k*ARCH_W +: ARCH_W];
      end
    end
  end

  assign ar_hs = o_arvalid & o_arready;

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q    <= StIdle;
      lock_idx_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (o_arvalid && !o_arready) begin
            state_q    <= StLocked;
            lock_idx_q <= grant_idx;
          end
        end
        StLocked: begin
          if (ar_hs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign head_idx = fifo_q[rd_ptr_q];

  always_comb begin
    i_rch    = o_rch;
    i_rvalid = '0;
    i_rlast  = '0;
    o_rready = 1'b0;
    for (int unsigned k = 0; k < MST_NB; k++) begin
      if (head_idx == IdxW'(k)) begin
        i_rvalid[k] = o_rvalid & ~empty & ~srst;
        i_rlast[k]  = o_rlast & ~empty & ~srst;
        o_rready    = i_rready[k] & ~empty & ~srst;
      end
    end
  end

  assign r_pop = o_rvalid & o_rready & o_rlast;

  always_ff @(posedge aclk) begin
    if (ar_hs) fifo_q[wr_ptr_q] <= grant_idx;
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (ar_hs) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (r_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (ar_hs && !r_pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!ar_hs && r_pop) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axicb_mst_switch_rd.sv
// Bench for axicb_mst_switch_rd: vector table for arbitration/routing plus corner-case sequences.
module tb_axicb_mst_switch_rd;

  logic        aclk = 1'b0;
  logic        srst;
  logic [3:0]  i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [31:0] i_arch;
  logic [7:0]  i_rch, o_arch, o_rch;
  logic        o_arvalid, o_arready, o_rvalid, o_rready, o_rlast;

  always #5 aclk = ~aclk;

  axicb_mst_switch_rd #(
    .MST_NB     (4),
    .ARCH_W     (8),
    .RCH_W      (8),
    .OSTDREQ_NB (4)
  ) dut (
    .aclk      (aclk),
    .srst      (srst),
    .i_arvalid (i_arvalid),
    .i_arready (i_arready),
    .i_arch    (i_arch),
    .i_rvalid  (i_rvalid),
    .i_rready  (i_rready),
    .i_rlast   (i_rlast),
    .i_rch     (i_rch),
    .o_arvalid (o_arvalid),
    .o_arready (o_arready),
    .o_arch    (o_arch),
    .o_rvalid  (o_rvalid),
    .o_rready  (o_rready),
    .o_rlast   (o_rlast),
    .o_rch     (o_rch)
  );

  typedef struct packed {
    logic [3:0] arvalid;
    logic       arready;
    logic       rvalid;
    logic       rlast;
    logic [3:0] rready;
    logic       e_arvalid;
    logic [3:0] e_arready;
    logic [7:0] e_arch;
    logic [3:0] e_rvalid;
    logic [3:0] e_rlast;
    logic       e_rready;
  } vec_t;

  vec_t        tbl[9];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_idle();
    i_arvalid = '0;
    o_arready = 1'b0;
    o_rvalid  = 1'b0;
    o_rlast   = 1'b0;
    i_rready  = '0;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    set_idle();
    tick();
    tick();
    srst = 1'b0;
    sb_q.delete();
  endtask

  // Pops the next expected master and compares it with the routed one-hot.
  task automatic sb_route(input string name);
    int unsigned exp;
    logic [3:0]  oh;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got beat %0h expected no outstanding burst", name, i_rvalid);
    end else begin
      exp = sb_q.pop_front();
      oh  = 4'b0001 << exp;
      check(name, 32'(i_rvalid), 32'(oh));
    end
  endtask

  function automatic int unsigned oh2idx(input logic [3:0] v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    i_arch = 32'hA3A2A1A0;
    o_rch  = 8'h5C;
    srst   = 1'b1;
    set_idle();

    // During reset: requests and beats present, everything gated.
    i_arvalid = 4'hF;
    o_arready = 1'b1;
    o_rvalid  = 1'b1;
    o_rlast   = 1'b1;
    i_rready  = 4'hF;
    tick();
    tick();
    #3;
    check("rst o_arvalid", 32'(o_arvalid), 0);
    check("rst i_arready", 32'(i_arready), 0);
    check("rst i_rvalid", 32'(i_rvalid), 0);
    check("rst i_rlast", 32'(i_rlast), 0);
    check("rst o_rready", 32'(o_rready), 0);
    check("rst o_arch", 32'(o_arch), 'hA0);
    check("rst i_rch", 32'(i_rch), 'h5C);
    tick();
    do_reset();

    //             arv  ard   rv    rl    rrdy  e_arv e_ard e_arch e_rv e_rl e_rrdy
    tbl[0] = '{4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 4'h1, 8'hA0, 4'h0, 4'h0, 1'b0};
    tbl[1] = '{4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 4'h2, 8'hA1, 4'h1, 4'h1, 1'b1};
    tbl[2] = '{4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 4'h4, 8'hA2, 4'h2, 4'h2, 1'b1};
    tbl[3] = '{4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 4'h8, 8'hA3, 4'h4, 4'h4, 1'b1};
    tbl[4] = '{4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 4'h1, 8'hA0, 4'h8, 4'h8, 1'b1};
    tbl[5] = '{4'h0, 1'b1, 1'b1, 1'b1, 4'hE, 1'b0, 4'h1, 8'hA0, 4'h1, 4'h1, 1'b0};
    tbl[6] = '{4'h0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 4'h1, 8'hA0, 4'h1, 4'h0, 1'b1};
    tbl[7] = '{4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 4'h1, 8'hA0, 4'h1, 4'h1, 1'b1};
    tbl[8] = '{4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 4'h1, 8'hA0, 4'h0, 4'h0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      r = tbl[i];
      i_arvalid = r.arvalid;
      o_arready = r.arready;
      o_rvalid  = r.rvalid;
      o_rlast   = r.rlast;
      i_rready  = r.rready;
      #3;
      check($sformatf("tbl[%0d] o_arvalid", i), 32'(o_arvalid), 32'(r.e_arvalid));
      check($sformatf("tbl[%0d] i_arready", i), 32'(i_arready), 32'(r.e_arready));
      check($sformatf("tbl[%0d] o_arch", i), 32'(o_arch), 32'(r.e_arch));
      check($sformatf("tbl[%0d] i_rvalid", i), 32'(i_rvalid), 32'(r.e_rvalid));
      check($sformatf("tbl[%0d] i_rlast", i), 32'(i_rlast), 32'(r.e_rlast));
      check($sformatf("tbl[%0d] o_rready", i), 32'(o_rready), 32'(r.e_rready));
      if (r.rvalid && r.rlast && r.e_rready) sb_route($sformatf("tbl[%0d] sb order", i));
      if (r.e_arvalid && r.arready) sb_q.push_back(oh2idx(r.e_arready));
      tick();
    end

    // Single master 1, single-beat burst.
    do_reset();
    i_arvalid = 4'h2;
    o_arready = 1'b1;
    #3;
    check("s1 o_arvalid", 32'(o_arvalid), 1);
    check("s1 i_arready", 32'(i_arready), 'h2);
    check("s1 o_arch", 32'(o_arch), 'hA1);
    sb_q.push_back(1);
    tick();
    i_arvalid = 4'h0;
    o_rvalid  = 1'b1;
    o_rlast   = 1'b1;
    i_rready  = 4'h2;
    #3;
    check("s1 i_rlast", 32'(i_rlast), 'h2);
    check("s1 o_rready", 32'(o_rready), 1);
    sb_route("s1 route");
    tick();
    #3;
    check("s1 empty i_rvalid", 32'(i_rvalid), 0);
    check("s1 empty o_rready", 32'(o_rready), 0);
    tick();

    // Master 2 locked while slave stalls; master 0 arrives meanwhile.
    do_reset();
    i_arvalid = 4'h4;
    #3;
    check("lock grant arvalid", 32'(o_arvalid), 1);
    check("lock grant arch", 32'(o_arch), 'hA2);
    check("lock grant arready", 32'(i_arready), 0);
    tick();
    for (int c = 0; c < 2; c++) begin
      i_arvalid = 4'h5;
      #3;
      check($sformatf("lock hold arch c%0d", c), 32'(o_arch), 'hA2);
      check($sformatf("lock hold arready c%0d", c), 32'(i_arready), 0);
      tick();
    end
    o_arready = 1'b1;
    #3;
    check("lock release arready", 32'(i_arready), 'h4);
    check("lock release arch", 32'(o_arch), 'hA2);
    sb_q.push_back(2);
    tick();
    i_arvalid = 4'h1;
    #3;
    check("lock next arready", 32'(i_arready), 'h1);
    check("lock next arch", 32'(o_arch), 'hA0);
    sb_q.push_back(0);
    tick();
    i_arvalid = 4'h0;
    o_arready = 1'b0;
    i_rready  = 4'hF;
    o_rvalid  = 1'b1;
    for (int bu = 0; bu < 2; bu++) begin
      int unsigned exp;
      logic [3:0]  oh;
      exp = sb_q[0];
      oh  = 4'b0001 << exp;
      for (int b = 0; b < 4; b++) begin
        o_rlast = (b == 3);
        #3;
        if (b == 3) sb_route($sformatf("burst%0d last", bu));
        else check($sformatf("burst%0d beat%0d", bu, b), 32'(i_rvalid), 32'(oh));
        tick();
      end
    end

    // Queue full: fifth AR blocked, including on the cycle the first burst ends.
    do_reset();
    i_arvalid = 4'hF;
    o_arready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #3;
      check($sformatf("full fill g%0d", g), 32'(i_arready), 32'(4'b0001 << g));
      sb_q.push_back(g);
      tick();
    end
    o_rvalid = 1'b1;
    i_rready = 4'hF;
    for (int b = 0; b < 4; b++) begin
      o_rlast = (b == 3);
      #3;
      check($sformatf("full block b%0d", b), 32'(i_arready), 0);
      check($sformatf("full arvalid b%0d", b), 32'(o_arvalid), 0);
      if (b == 3) sb_route("full pop route");
      else check($sformatf("full route b%0d", b), 32'(i_rvalid), 'h1);
      tick();
    end
    o_rvalid = 1'b0;
    #3;
    check("full accept after pop", 32'(i_arready), 'h1);
    check("full accept arvalid", 32'(o_arvalid), 1);
    tick();

    // Push and pop in the same cycle at count 2.
    do_reset();
    o_arready = 1'b1;
    i_arvalid = 4'h2;
    #3;
    check("pp push m1", 32'(i_arready), 'h2);
    sb_q.push_back(1);
    tick();
    i_arvalid = 4'h8;
    #3;
    check("pp push m3", 32'(i_arready), 'h8);
    sb_q.push_back(3);
    tick();
    i_arvalid = 4'h1;
    o_rvalid  = 1'b1;
    o_rlast   = 1'b1;
    i_rready  = 4'hF;
    #3;
    check("pp push m0", 32'(i_arready), 'h1);
    sb_route("pp pop m1");
    sb_q.push_back(0);
    tick();
    i_arvalid = 4'h0;
    #3;
    sb_route("pp route m3");
    tick();
    #3;
    sb_route("pp route m0");
    tick();
    #3;
    check("pp drained i_rvalid", 32'(i_rvalid), 0);
    check("pp drained o_rready", 32'(o_rready), 0);
    tick();

    // Reset in the middle of a burst.
    do_reset();
    o_arready = 1'b1;
    i_arvalid = 4'h2;
    #3;
    check("mid ar m1", 32'(i_arready), 'h2);
    tick();
    i_arvalid = 4'h0;
    o_arready = 1'b0;
    o_rvalid  = 1'b1;
    o_rlast   = 1'b0;
    i_rready  = 4'hF;
    #3;
    check("mid beat0", 32'(i_rvalid), 'h2);
    tick();
    srst = 1'b1;
    #3;
    check("mid rst i_rvalid", 32'(i_rvalid), 0);
    check("mid rst o_rready", 32'(o_rready), 0);
    tick();
    srst      = 1'b0;
    i_arvalid = 4'hF;
    o_arready = 1'b1;
    #3;
    check("mid after i_rvalid", 32'(i_rvalid), 0);
    check("mid after o_rready", 32'(o_rready), 0);
    check("mid after grant m0", 32'(i_arready), 'h1);
    tick();

    set_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
